softmax_normalizer: RTL and testbench
=====================================

# softmax_normalizer

Consumer stage placed directly after `exponential` in the softmax datapath. It collects a frame of `INPUTMAX` unsigned fixed-point exponentials and accumulates their sum. It then emits each element divided by that sum, in input order, using a sequential restoring divider. The result is a stream of normalized probabilities for downstream argmax or readout logic.

## Interface
- `DATALENGTH`, default 32: data width of input and output samples.
- `INPUTMAX`, default 5: elements per frame.
- `FRACBITS`, default 16: fractional bits of the unsigned Qm.FRACBITS format on both input and output.

- `Clock`, input, 1: single clock; all state updates on the rising edge.
- `Reset`, input, 1: synchronous, active-high; clears all state on the next rising edge.
- `Datain`, input, `DATALENGTH`: exponential sample, unsigned, `FRACBITS` fractional bits.
- `DataInValid`, input, 1: `Datain` is valid this cycle.
- `Ready`, output, 1: block accepts input this cycle.
- `DataOut`, output, `DATALENGTH`: normalized element, equal to `floor(e_k * 2^FRACBITS / sum)`.
- `DataOutValid`, output, 1: one-cycle pulse per output element.
- `Done`, output, 1: one-cycle pulse coincident with the last `DataOutValid` of a frame.
- `DivByZero`, output, 1: high with every `DataOutValid` of a frame whose sum is 0.

## Operation
- **FSM states:** IDLE, INPUTSTREAM, OP.
- **Reset:** state IDLE, element counter 0, sum 0, buffer contents don't-care. Output values after reset:
  - `Ready` = 1
  - `DataOut` = 0
  - `DataOutValid`, `Done`, `DivByZero` = 0
- **Input transfer:** a sample transfers on a rising edge where `DataInValid && Ready`.
  - The sample is written to `buffer[count]`, `sum += Datain`, and `count++`.
- **IDLE → INPUTSTREAM:** on the first transfer.
- **INPUTSTREAM:**
  - Stays in INPUTSTREAM while `count < INPUTMAX`.
  - Gaps (`DataInValid` = 0) are allowed and do not affect the frame.
  - When the `INPUTMAX`-th transfer occurs, the next state is OP and `Ready` drops to 0.
- **Sum register:** width `DATALENGTH + clog2(INPUTMAX)`, so it never overflows.
- **OP:**
  - Processes elements k = 0..`INPUTMAX`-1 in order.
  - Each element uses 1 load cycle followed by `FRACBITS+1` restoring-division iterations.
  - Dividend is `buffer[k] << FRACBITS`; divisor is `sum`.
  - `FRACBITS+1` quotient bits are enough because `e_k ≤ sum`, so the quotient is ≤ 2^FRACBITS.
  - The quotient is zero-extended to `DATALENGTH` bits.
- **Sum = 0:** the divider is bypassed in timing only. Per-element cadence is unchanged, `DataOut` = 0, and `DivByZero` = 1 with each valid.
- **`DataOut` hold:** holds its last value between valids and is not cleared at frame end.
- **`DataInValid` during OP:** ignored, since `Ready` = 0. No sample is buffered and the sum is unchanged.
- **End of frame:** after the last element, `Done` pulses with `DataOutValid`. On the same edge the state returns to IDLE and sum and count clear; `Ready` = 1 from the following cycle.
- **`Reset` mid-frame (any state):** the partial frame is discarded. No further `DataOutValid` or `Done` is issued for that frame.

## Timing
- Define edge T0 as the edge that accepts the last input sample of a frame.
- `DataOutValid` for element k rises after edge T0 + (FRACBITS+2)·(k+1) and stays high for exactly one cycle. With defaults this is after T0+18, T0+36, …, T0+90.
- Frame output latency: (FRACBITS+2)·INPUTMAX cycles, which is 90 with defaults.
- `Ready` is 0 from after T0 through the cycle holding the last `DataOutValid`, and is 1 from the next cycle.
- Input throughput: one sample per cycle in IDLE and INPUTSTREAM.
- No output backpressure: downstream logic must capture `DataOut` on `DataOutValid`.

## Test plan
- **Equal inputs:** five samples of 0x00010000 on consecutive cycles → five outputs of 0x00003333, `DivByZero` = 0, `Done` with the 5th output, first valid after T0+18.
- **Mixed values with gaps:** 0x00020000, 0x00020000, 0x00040000, 0, 0, with 3 idle cycles between samples → outputs 0x00004000, 0x00004000, 0x00008000, 0, 0; spacing exactly 18 cycles.
- **All-zero frame:** five samples of 0 → five outputs of 0, `DivByZero` = 1 on each valid, `Done` on the last, `Ready` = 1 afterwards.
- **Maximum values:** five samples of 0xFFFFFFFF → sum 0x4FFFFFFFB (35 bits, no overflow), each output 0x00003333. A second frame of 0xFFFFFFFF, 0, 0, 0, 0 → outputs 0x00010000, 0, 0, 0, 0.
- **Reset mid-frame:** feed 3 samples, assert `Reset` for 1 cycle, then a full frame of 0x00010000 ×5 → exactly five outputs of 0x00003333, no residue from the discarded samples. A second check asserts `Reset` mid-OP → `DataOutValid`, `Done`, `DataOut` = 0 and `Ready` = 1 after the reset edge.
- **Input during OP:** hold `DataInValid` = 1 with 0x12345678 throughout OP → `Ready` = 0, outputs unaffected, and the next frame's sum excludes that value.

Source files
------------

// File: rtl/softmax_normalizer.sv
// Softmax normalizer: buffers a frame of exponentials, sums them, then emits
// each element divided by the sum through a sequential restoring divider.
module softmax_normalizer #(
    parameter int DATALENGTH = 32,
    parameter int INPUTMAX   = 5,
    parameter int FRACBITS   = 16
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [DATALENGTH-1:0] Datain,
    input  logic                  DataInValid,
    output logic                  Ready,
    output logic [DATALENGTH-1:0] DataOut,
    output logic                  DataOutValid,
    output logic                  Done,
    output logic                  DivByZero
);
    localparam int SUMW = DATALENGTH + $clog2(INPUTMAX);
    localparam int CW   = $clog2(INPUTMAX + 1);
    localparam int QW   = FRACBITS + 1;
    localparam int IW   = $clog2(QW + 1);

    typedef enum logic [1:0] {IDLE, INPUTSTREAM, OP} state_t;

    state_t                state;
    logic [CW-1:0]         count;
    logic [CW-1:0]         elem;
    logic [IW-1:0]         iter;
    logic                  loading;
    logic [SUMW-1:0]       sum;
    logic [SUMW-1:0]       rem;
    logic [QW-1:0]         bits;
    logic [QW-2:0]         quo;
    logic [DATALENGTH-1:0] buffer [INPUTMAX];

    logic                  take;
    logic [SUMW:0]         rem_shift;
    logic [SUMW:0]         diff;
    logic                  fits;
    logic [SUMW-1:0]       rem_next;
    logic [QW-1:0]         quo_next;

    // NOTE: combinational logic uses blocking '=' and assigns every output
    // on every path, so no latch can be inferred.
    always_comb begin
        take      = DataInValid && Ready;
        rem_shift = {rem, bits[QW-1]};
        diff      = rem_shift - {1'b0, sum};
        fits      = ~diff[SUMW];
        rem_next  = fits ? diff[SUMW-1:0] : rem_shift[SUMW-1:0];
        quo_next  = {quo, fits};
    end

    // NOTE: the sample buffer is a plain memory with no reset; every slot is
    // rewritten before it is read in a frame.
    always_ff @(posedge Clock) begin
        if (take)
            buffer[count] <= Datain;
    end

    // NOTE: sequential state uses non-blocking '<=' so every register sees
    // pre-edge values regardless of statement order.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state        <= IDLE;
            count        <= '0;
            elem         <= '0;
            iter         <= '0;
            loading      <= 1'b0;
            sum          <= '0;
            rem          <= '0;
            bits         <= '0;
            quo          <= '0;
            Ready        <= 1'b1;
            DataOut      <= '0;
            DataOutValid <= 1'b0;
            Done         <= 1'b0;
            DivByZero    <= 1'b0;
        end else begin
            DataOutValid <= 1'b0;
            Done         <= 1'b0;
            DivByZero    <= 1'b0;
            case (state)
                IDLE, INPUTSTREAM: begin
                    Ready <= 1'b1;
                    if (take) begin
                        sum   <= sum + SUMW'(Datain);
                        count <= count + 1'b1;
                        if (count == CW'(INPUTMAX - 1)) begin
                            state   <= OP;
                            Ready   <= 1'b0;
                            elem    <= '0;
                            loading <= 1'b1;
                        end else begin
                            state <= INPUTSTREAM;
                        end
                    end
                end
                OP: begin
                    if (loading) begin
                        // Top dividend bits (e >> 1) start as the partial
                        // remainder; the quotient then fits in QW bits.
                        rem     <= SUMW'(buffer[elem] >> 1);
                        bits    <= {buffer[elem][0], {FRACBITS{1'b0}}};
                        quo     <= '0;
                        iter    <= '0;
                        loading <= 1'b0;
                    end else begin
                        rem  <= rem_next;
                        bits <= {bits[QW-2:0], 1'b0};
                        quo  <= quo_next[QW-2:0];
                        iter <= iter + 1'b1;
                        if (iter == IW'(QW - 1)) begin
                            DataOutValid <= 1'b1;
                            DivByZero    <= (sum == '0);
                            DataOut      <= (sum == '0) ? '0 : DATALENGTH'(quo_next);
                            loading      <= 1'b1;
                            elem         <= elem + 1'b1;
                            if (elem == CW'(INPUTMAX - 1)) begin
                                Done    <= 1'b1;
                                state   <= IDLE;
                                sum     <= '0;
                                count   <= '0;
                                loading <= 1'b0;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_softmax_normalizer.sv
// Directed bench for softmax_normalizer: hand-computed frames checked with
// immediate assertions, including timing, zero sums, maxima and resets.
module tb_softmax_normalizer;
    logic        Clock = 1'b0;
    logic        Reset;
    logic [31:0] Datain;
    logic        DataInValid;
    logic        Ready;
    logic [31:0] DataOut;
    logic        DataOutValid;
    logic        Done;
    logic        DivByZero;

    int total = 0;
    int bad   = 0;

    typedef logic [31:0] frame_t [5];

    softmax_normalizer dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .Datain      (Datain),
        .DataInValid (DataInValid),
        .Ready       (Ready),
        .DataOut     (DataOut),
        .DataOutValid(DataOutValid),
        .Done        (Done),
        .DivByZero   (DivByZero)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge Clock);
            #1;
        end
    endtask

    // One sample transfers on the next edge, then `gap` idle cycles follow.
    task automatic send(input logic [31:0] d, input int gap);
        Datain      = d;
        DataInValid = 1'b1;
        tick(1);
        DataInValid = 1'b0;
        Datain      = '0;
        if (gap > 0) tick(gap);
    endtask

    task automatic send_frame(input frame_t f, input int gap);
        for (int i = 0; i < 5; i++)
            send(f[i], (i == 4) ? 0 : gap);
    endtask

    // Called just after edge T0; each valid must come exactly 18 edges later.
    task automatic expect_frame(input string tag, input frame_t exp, input logic dbz);
        for (int k = 0; k < 5; k++) begin
            int waited = 0;
            do begin
                tick(1);
                waited++;
            end while (!DataOutValid && waited < 40);
            check($sformatf("%s[%0d] latency", tag, k), waited, 18);
            check($sformatf("%s[%0d] data", tag, k), DataOut, exp[k]);
            check($sformatf("%s[%0d] divbyzero", tag, k), DivByZero, dbz);
            check($sformatf("%s[%0d] done", tag, k), Done, (k == 4));
            check($sformatf("%s[%0d] ready_low", tag, k), Ready, 1'b0);
        end
        tick(1);
        check({tag, " ready_after"}, Ready, 1'b1);
        check({tag, " valid_after"}, DataOutValid, 1'b0);
        check({tag, " dataout_hold"}, DataOut, exp[4]);
    endtask

    initial begin
        frame_t ones, q_ones, mixed, q_mixed, zeros, maxv, max1, q_max1;
        int valids;

        ones    = '{32'h00010000, 32'h00010000, 32'h00010000, 32'h00010000, 32'h00010000};
        q_ones  = '{32'h00003333, 32'h00003333, 32'h00003333, 32'h00003333, 32'h00003333};
        mixed   = '{32'h00020000, 32'h00020000, 32'h00040000, 32'h0, 32'h0};
        q_mixed = '{32'h00004000, 32'h00004000, 32'h00008000, 32'h0, 32'h0};
        zeros   = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        maxv    = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
        max1    = '{32'hFFFFFFFF, 32'h0, 32'h0, 32'h0, 32'h0};
        q_max1  = '{32'h00010000, 32'h0, 32'h0, 32'h0, 32'h0};

        Reset       = 1'b1;
        Datain      = '0;
        DataInValid = 1'b0;
        tick(2);
        Reset = 1'b0;
        check("reset ready", Ready, 1'b1);
        check("reset dataout", DataOut, 32'h0);
        check("reset valid", DataOutValid, 1'b0);
        check("reset done", Done, 1'b0);
        check("reset divbyzero", DivByZero, 1'b0);

        send_frame(ones, 0);
        expect_frame("equal", q_ones, 1'b0);

        send_frame(mixed, 3);
        expect_frame("mixed_gaps", q_mixed, 1'b0);

        send_frame(zeros, 0);
        expect_frame("all_zero", zeros, 1'b1);

        send_frame(maxv, 0);
        expect_frame("max_all", q_ones, 1'b0);
        send_frame(max1, 0);
        expect_frame("max_one", q_max1, 1'b0);

        // Partial frame discarded by a reset during input streaming.
        send(32'h00070000, 0);
        send(32'h00090000, 0);
        send(32'h00030000, 0);
        Reset = 1'b1;
        tick(1);
        Reset = 1'b0;
        check("rst_stream ready", Ready, 1'b1);
        send_frame(ones, 0);
        expect_frame("after_rst_stream", q_ones, 1'b0);

        // Reset while dividing: nothing further may come out of that frame.
        send_frame(mixed, 0);
        tick(30);
        Reset = 1'b1;
        tick(1);
        Reset = 1'b0;
        check("rst_op valid", DataOutValid, 1'b0);
        check("rst_op done", Done, 1'b0);
        check("rst_op dataout", DataOut, 32'h0);
        check("rst_op ready", Ready, 1'b1);
        valids = 0;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            if (DataOutValid || Done) valids++;
        end
        check("rst_op no_residue", valids, 0);

        // Input held valid throughout OP must be ignored.
        send_frame(ones, 0);
        Datain      = 32'h12345678;
        DataInValid = 1'b1;
        expect_frame("busy_input", q_ones, 1'b0);
        DataInValid = 1'b0;
        Datain      = '0;
        send_frame(mixed, 0);
        expect_frame("after_busy", q_mixed, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
